memory_stage: RTL and testbench

- MEM stage of the 5-stage RV64 pipeline, between the EX/MEM pipeline register and the MEM/WB register.
- Consumes execute_data_t and issues LD/SD on the data bus with a valid/addr_ok/data_ok handshake.
- Registers a memory_data_t result and drives a forward_data_out for the hazard unit.
- Stalls upstream while a bus access is outstanding.

---
 rtl/memory_stage_pkg.sv | 53 +++++
 rtl/memory_stage_bus_fsm.sv | 97 +++++++++
 rtl/memory_stage.sv | 126 ++++++++++++
 tb/tb_memory_stage.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared pipeline types for the MEM stage.
// Holds the EX/MEM and MEM/WB payload structs, the forwarding bundle, the
// bus FSM state encoding and the fixed bus access size.
package memory_stage_pkg;

  localparam logic [2:0] MSIZE8 = 3'b011;

  typedef enum logic [1:0] {MEM_IDLE, MEM_ADDR, MEM_DATA} mem_state_t;

  typedef enum logic [5:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LD, OP_SD, OP_JAL
  } decoded_op_t;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
  } control_t;

  // 303 bits
  typedef struct packed {
    logic [63:0] pc;
    decoded_op_t op;
    logic [31:0] instruction;
    logic        jump;
    logic [63:0] target;
    control_t    ctl;
    logic [4:0]  dst;
    logic [63:0] result;
    logic [63:0] memdata;
  } execute_data_t;

  // 238 bits
  typedef struct packed {
    logic [63:0] pc;
    decoded_op_t op;
    logic [31:0] instruction;
    logic        jump;
    logic        regwrite;
    logic [4:0]  dst;
    logic [63:0] regdata;
    logic        skip;
    logic [63:0] address;
  } memory_data_t;

  // 70 bits
  typedef struct packed {
    logic        valid;
    logic [4:0]  dst;
    logic [63:0] data;
  } forward_data_out;

endpackage

// File: rtl/memory_stage_bus_fsm.sv
// mem_bus_fsm: drives one LD/SD on the data bus.
// Ports: start/is_store/addr/wdata capture a request while idle; dreq_* is the
// request side, dresp_* the response side; done pulses when the access has
// finished and the stage may load its output (held off by wb_stall); rdata
// is the load data valid with done.
module mem_bus_fsm
  import memory_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic        wb_stall,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        idle,
  output logic        done,
  output logic [63:0] rdata,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data
);

  mem_state_t  state_q, state_d;
  logic [63:0] addr_q, data_q, rdata_q;
  logic [7:0]  strobe_q;
  logic        got_q;   // data phase already finished, waiting on wb_stall
  logic        data_arrive;

  assign idle        = (state_q == MEM_IDLE);
  assign dreq_addr   = addr_q;
  assign dreq_data   = data_q;
  assign dreq_strobe = strobe_q;
  assign dreq_size   = MSIZE8;
  assign rdata       = got_q ? rdata_q : dresp_data;

  // Data that shows up while downstream is stalled is parked in rdata_q.
  assign data_arrive = dresp_data_ok && !got_q &&
                       ((state_q == MEM_ADDR && dresp_addr_ok) || state_q == MEM_DATA);

  always_comb begin
    state_d    = state_q;
    done       = 1'b0;
    dreq_valid = 1'b0;
    case (state_q)
      MEM_IDLE: if (start) state_d = MEM_ADDR;
      MEM_ADDR: begin
        dreq_valid = 1'b1;
        if (dresp_addr_ok) begin
          if (dresp_data_ok && !wb_stall) begin
            done    = 1'b1;
            state_d = MEM_IDLE;
          end else begin
            state_d = MEM_DATA;
          end
        end
      end
      MEM_DATA: begin
        if ((got_q || dresp_data_ok) && !wb_stall) begin
          done    = 1'b1;
          state_d = MEM_IDLE;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MEM_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      strobe_q <= '0;
      got_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start && idle) begin
        addr_q   <= addr & ~64'h7;  // misaligned accesses go out doubleword aligned
        data_q   <= wdata;
        strobe_q <= is_store ? 8'hFF : 8'h00;
      end
      if (done) begin
        got_q <= 1'b0;
      end else if (data_arrive) begin
        got_q   <= 1'b1;
        rdata_q <= dresp_data;
      end
    end
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: MEM stage of the RV64 pipeline.
// Ports: in_valid/ex_data/in_ready from EX/MEM; wb_stall and flush from the
// pipeline control; dreq_*/dresp_* data bus; out_valid/out_data to MEM/WB;
// fwd to the hazard unit; misalign pulses one cycle after accepting a
// misaligned LD/SD.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int MMIO_BIT = 31
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  execute_data_t   ex_data,
  output logic            in_ready,
  input  logic            wb_stall,
  input  logic            flush,
  output logic            dreq_valid,
  output logic [63:0]     dreq_addr,
  output logic [2:0]      dreq_size,
  output logic [7:0]      dreq_strobe,
  output logic [63:0]     dreq_data,
  input  logic            dresp_addr_ok,
  input  logic            dresp_data_ok,
  input  logic [63:0]     dresp_data,
  output logic            out_valid,
  output memory_data_t    out_data,
  output forward_data_out fwd,
  output logic            misalign
);

  logic         idle, done, accept, is_mem, start;
  logic         is_ld_q, flushed_q;
  logic [63:0]  rdata;
  memory_data_t alu_data, mem_cap, held_q, done_data;
  logic         unused_target;

  assign unused_target = ^ex_data.target;

  assign in_ready = idle && !wb_stall;
  assign accept   = in_valid && in_ready;
  assign is_mem   = ex_data.ctl.memread || ex_data.ctl.memwrite;
  assign start    = accept && is_mem;

  mem_bus_fsm u_bus (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .is_store     (ex_data.ctl.memwrite),
    .addr         (ex_data.result),
    .wdata        (ex_data.memdata),
    .wb_stall     (wb_stall),
    .dresp_addr_ok(dresp_addr_ok),
    .dresp_data_ok(dresp_data_ok),
    .dresp_data   (dresp_data),
    .idle         (idle),
    .done         (done),
    .rdata        (rdata),
    .dreq_valid   (dreq_valid),
    .dreq_addr    (dreq_addr),
    .dreq_size    (dreq_size),
    .dreq_strobe  (dreq_strobe),
    .dreq_data    (dreq_data)
  );

  always_comb begin
    alu_data             = '0;
    alu_data.pc          = ex_data.pc;
    alu_data.op          = ex_data.op;
    alu_data.instruction = ex_data.instruction;
    alu_data.jump        = ex_data.jump;
    alu_data.regwrite    = ex_data.ctl.regwrite;
    alu_data.dst         = ex_data.dst;
    alu_data.regdata     = ex_data.result;

    // Everything but the load data is known at acceptance.
    mem_cap          = alu_data;
    mem_cap.regwrite = ex_data.ctl.regwrite && (ex_data.op == OP_LD);
    mem_cap.regdata  = '0;
    mem_cap.skip     = !ex_data.result[MMIO_BIT];
    mem_cap.address  = ex_data.result;

    done_data = held_q;
    if (is_ld_q) done_data.regdata = rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      held_q    <= '0;
      is_ld_q   <= 1'b0;
      flushed_q <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      misalign <= start && (ex_data.result[2:0] != 3'b000);
      if (start) begin
        held_q  <= mem_cap;
        is_ld_q <= ex_data.ctl.memread;
      end
      // A flush seen anywhere in a bus access kills its result; the bus
      // transaction itself must still run to completion.
      if (done)
        flushed_q <= 1'b0;
      else if (flush && (!idle || start))
        flushed_q <= 1'b1;

      if (flush) begin
        out_valid <= 1'b0;
      end else if (done) begin
        out_valid <= !flushed_q;
        if (!flushed_q) out_data <= done_data;
      end else if (in_ready) begin
        out_valid <= accept && !is_mem;
        if (accept && !is_mem) out_data <= alu_data;
      end
    end
  end

  always_comb begin
    fwd.valid = out_valid && out_data.regwrite && (out_data.dst != 5'd0);
    fwd.dst   = out_data.dst;
    fwd.data  = out_data.regdata;
  end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready, wb_stall, flush;
  execute_data_t ex_data;
  logic dreq_valid;
  logic [63:0] dreq_addr, dreq_data;
  logic [2:0] dreq_size;
  logic [7:0] dreq_strobe;
  logic dresp_addr_ok, dresp_data_ok;
  logic [63:0] dresp_data;
  logic out_valid, misalign;
  memory_data_t out_data;
  forward_data_out fwd;

  always #5 clk = ~clk;

  memory_stage #(.MMIO_BIT(31)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ex_data(ex_data),
    .in_ready(in_ready), .wb_stall(wb_stall), .flush(flush),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data), .out_valid(out_valid), .out_data(out_data),
    .fwd(fwd), .misalign(misalign)
  );

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic        st;
  } bus_t;

  memory_data_t exp_q[$];
  bus_t         bus_q[$];
  memory_data_t last_exp = '0;
  int  n_chk = 0, n_fail = 0;
  logic mis_exp = 1'b0;
  logic ld_ovr_en = 1'b0;
  logic [63:0] ld_ovr = '0;
  logic stall_seen = 1'b0, flush_seen = 1'b0;
  // slave timing: cfg_mode 0 = random, 1 = fixed cfg_wa/cfg_comb/cfg_wd
  int cfg_mode = 0, cfg_wa = 0, cfg_wd = 0;
  bit cfg_comb = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Slave memory contents: a fixed function of the doubleword address.
  function automatic logic [63:0] mem_f(input logic [63:0] a);
    if (ld_ovr_en) return ld_ovr;
    return {a[31:0] ^ 32'hC0DE_F00D, ~a[31:0]};
  endfunction

  function automatic memory_data_t model(input execute_data_t e);
    memory_data_t m;
    logic [63:0] r;
    m = '0;
    r = e.result;
    m.pc = e.pc; m.op = e.op; m.instruction = e.instruction;
    m.jump = e.jump; m.dst = e.dst;
    if (!(e.ctl.memread || e.ctl.memwrite)) begin
      m.regwrite = e.ctl.regwrite;
      m.regdata  = r;
    end else begin
      m.regwrite = e.ctl.regwrite && (e.op == OP_LD);
      m.regdata  = e.ctl.memread ? mem_f({r[63:3], 3'b000}) : 64'd0;
      m.skip     = (r[31] == 1'b0);
      m.address  = r;
    end
    return m;
  endfunction

  function automatic execute_data_t rand_ins(input int kind);
    execute_data_t e;
    e = '0;
    e.pc = {$urandom, $urandom};
    e.instruction = $urandom;
    e.jump = 1'($urandom % 2);
    e.target = {$urandom, $urandom};
    e.dst = 5'($urandom);
    e.result = {$urandom, $urandom};
    e.memdata = {$urandom, $urandom};
    case (kind)
      1: begin e.op = OP_LD; e.ctl.memread = 1'b1; e.ctl.regwrite = 1'b1; end
      2: begin e.op = OP_SD; e.ctl.memwrite = 1'b1; e.ctl.regwrite = 1'($urandom % 2); end
      default: begin e.op = OP_ADD; e.ctl.regwrite = ($urandom % 4) != 0; end
    endcase
    if (kind != 0 && ($urandom % 4) != 0) e.result[2:0] = 3'b000;
    return e;
  endfunction

  // One clock of stimulus: drive, decide acceptance at negedge, advance.
  task automatic step(input logic v, input execute_data_t e, input logic st,
                      input logic fl, input logic exp_out, output logic acc);
    bus_t b;
    in_valid = v; ex_data = e; wb_stall = st; flush = fl;
    @(negedge clk);
    check("misalign", 256'(misalign), 256'(mis_exp));
    acc = in_valid && in_ready;
    mis_exp = acc && (e.ctl.memread || e.ctl.memwrite) && (e.result[2:0] != 3'b000);
    if (acc) begin
      if (exp_out && !fl) exp_q.push_back(model(e));
      if (e.ctl.memread || e.ctl.memwrite) begin
        b.addr = {e.result[63:3], 3'b000};
        b.strobe = e.ctl.memwrite ? 8'hFF : 8'h00;
        b.data = e.memdata;
        b.st = e.ctl.memwrite;
        bus_q.push_back(b);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic bubble(input logic st);
    logic acc;
    step(1'b0, '0, st, 1'b0, 1'b1, acc);
  endtask

  task automatic issue(input execute_data_t e, input logic rand_stall, input logic exp_out);
    logic acc;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, e, rand_stall && ($urandom % 4 == 0), 1'b0, exp_out, acc);
      if (acc) return;
    end
    fail_now("issue timeout");
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (in_ready && exp_q.size() == 0) return;
      bubble(1'b0);
    end
    fail_now("drain timeout");
  endtask

  // Bus slave
  initial begin : slave
    int ph, wa, wd;
    logic [63:0] saved;
    bit comb;
    ph = 0; wa = -1; wd = 0; saved = '0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
    forever begin
      @(negedge clk);
      dresp_addr_ok = 1'b0;
      dresp_data_ok = 1'b0;
      dresp_data = {$urandom, $urandom};
      if (reset) begin
        ph = 0; wa = -1;
      end else if (ph == 0) begin
        if (dreq_valid) begin
          if (bus_q.size() == 0) begin
            fail_now("unexpected dreq_valid");
          end else begin
            check("dreq_addr", 256'(dreq_addr), 256'(bus_q[0].addr));
            check("dreq_size", 256'(dreq_size), 256'(3'b011));
            check("dreq_strobe", 256'(dreq_strobe), 256'(bus_q[0].strobe));
            if (bus_q[0].st) check("dreq_data", 256'(dreq_data), 256'(bus_q[0].data));
          end
          if (wa < 0) wa = cfg_mode != 0 ? cfg_wa : int'($urandom_range(0, 3));
          if (wa > 0) begin
            wa--;
          end else begin
            wa = -1;
            dresp_addr_ok = 1'b1;
            saved = dreq_addr;
            if (bus_q.size() != 0) void'(bus_q.pop_front());
            comb = cfg_mode != 0 ? cfg_comb : bit'($urandom % 2);
            if (comb) begin
              dresp_data_ok = 1'b1;
              dresp_data = mem_f(saved);
            end else begin
              ph = 1;
              wd = cfg_mode != 0 ? cfg_wd : int'($urandom_range(0, 3));
            end
          end
        end
      end else begin
        if (wd > 0) begin
          wd--;
        end else begin
          dresp_data_ok = 1'b1;
          dresp_data = mem_f(saved);
          ph = 0;
        end
      end
    end
  end

  initial begin : edge_sampler
    forever begin
      @(posedge clk);
      stall_seen = wb_stall;
      flush_seen = flush;
    end
  end

  // Scoreboard monitor
  initial begin : monitor
    forward_data_out f;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (out_valid) begin
          if (flush_seen) begin
            check("out_valid after flush", 256'(out_valid), 256'(1'b0));
          end else if (stall_seen) begin
            check("out_data hold", 256'(out_data), 256'(last_exp));
          end else if (exp_q.size() == 0) begin
            fail_now("unexpected out_valid");
          end else begin
            last_exp = exp_q.pop_front();
            check("out_data", 256'(out_data), 256'(last_exp));
          end
          f.valid = last_exp.regwrite && (last_exp.dst != 5'd0);
          f.dst = last_exp.dst;
          f.data = last_exp.regdata;
          check("fwd", 256'(fwd), 256'(f));
        end else begin
          check("fwd.valid idle", 256'(fwd.valid), 256'(1'b0));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : main
    execute_data_t e;
    memory_data_t prev;
    logic acc;
    int n;
    reset = 1'b1; in_valid = 1'b0; ex_data = '0; wb_stall = 1'b0; flush = 1'b0;
    #2;
    check("reset out_valid", 256'(out_valid), 256'(1'b0));
    check("reset out_data", 256'(out_data), 256'(0));
    check("reset dreq_valid", 256'(dreq_valid), 256'(1'b0));
    check("reset dreq_addr", 256'(dreq_addr), 256'(0));
    check("reset dreq_strobe", 256'(dreq_strobe), 256'(0));
    check("reset fwd", 256'(fwd), 256'(0));
    check("reset misalign", 256'(misalign), 256'(1'b0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("in_ready after reset", 256'(in_ready), 256'(1'b1));

    // ADD: one-cycle latency, forwarded
    e = rand_ins(0);
    e.result = 64'h1234; e.dst = 5'd5; e.ctl.regwrite = 1'b1;
    issue(e, 1'b0, 1'b1);
    check("add out_valid", 256'(out_valid), 256'(1'b1));
    check("add fwd", 256'(fwd), 256'({1'b1, 5'd5, 64'h1234}));
    bubble(1'b0);

    // LD from RAM with split address/data phases
    cfg_mode = 1; cfg_wa = 1; cfg_comb = 0; cfg_wd = 1;
    ld_ovr_en = 1'b1; ld_ovr = 64'hDEADBEEF;
    e = rand_ins(1); e.result = 64'h8000_1000;
    issue(e, 1'b0, 1'b1);
    check("ld in_ready busy", 256'(in_ready), 256'(1'b0));
    drain();
    check("ld regdata", 256'(last_exp.regdata), 256'(64'hDEADBEEF));
    check("ld out regdata", 256'(out_data.regdata), 256'(64'hDEADBEEF));
    check("ld skip", 256'(out_data.skip), 256'(1'b0));
    ld_ovr_en = 1'b0;

    // SD to MMIO, address and data ok together
    cfg_wa = 0; cfg_comb = 1;
    e = rand_ins(2); e.result = 64'h4000_0008; e.memdata = 64'hAA55; e.ctl.regwrite = 1'b1;
    issue(e, 1'b0, 1'b1);
    drain();
    check("sd regwrite", 256'(out_data.regwrite), 256'(1'b0));
    check("sd skip", 256'(out_data.skip), 256'(1'b1));
    prev = out_data;

    // LD completing under wb_stall
    cfg_comb = 0; cfg_wd = 0;
    e = rand_ins(1); e.result = 64'h8000_2010;
    issue(e, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b1, acc);
      check("stall out_data", 256'(out_data), 256'(prev));
      check("stall out_valid", 256'(out_valid), 256'(1'b0));
    end
    drain();
    repeat (2) bubble(1'b0);

    // LD flushed while in the data phase
    cfg_wd = 2;
    e = rand_ins(1); e.result = 64'h8000_3000; e.dst = 5'd7;
    issue(e, 1'b0, 1'b0);
    bubble(1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, acc);
    n = 0;
    while (!in_ready && n < 20) begin bubble(1'b0); n++; end
    bubble(1'b0);
    check("flush out_valid", 256'(out_valid), 256'(1'b0));
    check("flush fwd.valid", 256'(fwd.valid), 256'(1'b0));
    check("flush bus drained", 256'(bus_q.size()), 256'(0));

    // Reset in the middle of the address phase
    cfg_wa = 8;
    e = rand_ins(1); e.result = 64'h8000_4000;
    issue(e, 1'b0, 1'b1);
    bubble(1'b0);
    #2 reset = 1'b1;
    #1;
    check("midreset dreq_valid", 256'(dreq_valid), 256'(1'b0));
    check("midreset out_valid", 256'(out_valid), 256'(1'b0));
    exp_q.delete(); bus_q.delete(); mis_exp = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    e = rand_ins(0); e.dst = 5'd9; e.ctl.regwrite = 1'b1;
    issue(e, 1'b0, 1'b1);
    check("post-reset fwd.dst", 256'(fwd.dst), 256'(5'd9));
    drain();

    // Random traffic with random stalls and slave timing
    cfg_mode = 0;
    for (int i = 0; i < 300; i++) begin
      while ($urandom % 3 == 0) bubble(1'($urandom % 4 == 0));
      issue(rand_ins(int'($urandom % 3)), 1'b1, 1'b1);
    end
    drain();
    repeat (3) bubble(1'b0);
    check("scoreboard empty", 256'(exp_q.size()), 256'(0));
    check("bus queue empty", 256'(bus_q.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
